// File: rtl/qpsk_mul_share_arb.sv
// qpsk_mul_share_arb
// Round-robin arbiter that time-shares one pipelined 15u x 15s multiplier among
// N_REQ requesters. A {vld, id} shadow pipeline follows the multiplier latency,
// so every product leaves tagged with the requester that issued it. A stalled
// result (res_valid & ~res_ready) freezes the multiplier, the shadow pipeline
// and the round-robin pointer together.
module qpsk_mul_share_arb #(
  parameter int N_REQ   = 4,   // number of requesters, 2..8
  parameter int ID_W    = 2,   // requester id width, 2**ID_W >= N_REQ
  parameter int MUL_LAT = 3    // ce-enabled edges from din0/din1 to dout
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [15*N_REQ-1:0] req_a,
  input  logic [15*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]    req_ready,
  output logic                mul_ce,
  output logic [14:0]         mul_din0,
  output logic [14:0]         mul_din1,
  input  logic [29:0]         mul_dout,
  output logic                res_valid,
  output logic [29:0]         res_data,
  output logic [ID_W-1:0]     res_id,
  input  logic                res_ready,
  output logic                busy
);

  // Shadow pipeline: one {vld, id} pair per multiplier stage.
  logic [MUL_LAT-1:0] r_vld;
  logic [ID_W-1:0]    r_id [MUL_LAT];
  // Index of the most recently granted requester; the search starts after it.
  logic [ID_W-1:0]    r_ptr;

  logic               w_ce;
  logic               w_grant_any;
  logic [ID_W-1:0]    w_grant_idx;
  logic [ID_W-1:0]    w_cand;
  logic [14:0]        w_a [N_REQ];
  logic [14:0]        w_b [N_REQ];

  // Unpack the operand buses and decode the one-hot grant per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
    assign w_a[gi]       = req_a[15*gi +: 15];
    assign w_b[gi]       = req_b[15*gi +: 15];
    assign req_ready[gi] = w_grant_any & (w_grant_idx == ID_W'(gi));
  end

  // The whole datapath advances only when the output stage is not blocked.
  // During reset r_vld is clear, so the multiplier stays enabled.
  assign w_ce = ~(res_valid & ~res_ready);

  // Round-robin search from ptr+1 with wrap; first valid requester wins.
  // Depends only on req_valid, ptr, ce and reset -- never on the operands.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = ID_W'((int'(r_ptr) + k) % N_REQ);
      if (!w_grant_any && req_valid[w_cand] && w_ce && reset_n) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_cand;
      end
    end
  end

  // Operand mux: winner's operands on a grant, zeros for a bubble.
  always_comb begin
    mul_din0 = '0;
    mul_din1 = '0;
    if (w_grant_any) begin
      mul_din0 = w_a[w_grant_idx];
      mul_din1 = w_b[w_grant_idx];
    end
  end

  // Shadow pipeline and pointer advance together with the multiplier.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        r_id[k] <= '0;
      end
      r_ptr <= ID_W'(N_REQ - 1);
    end else if (w_ce) begin
      r_vld[0] <= w_grant_any;
      r_id[0]  <= w_grant_idx;
      for (int k = 1; k < MUL_LAT; k++) begin
        r_vld[k] <= r_vld[k-1];
        r_id[k]  <= r_id[k-1];
      end
      if (w_grant_any) begin
        r_ptr <= w_grant_idx;
      end
    end
  end

  assign mul_ce    = w_ce;
  assign res_valid = r_vld[MUL_LAT-1];
  assign res_id    = r_id[MUL_LAT-1];
  // The multiplier holds its output while ce is low, so data is stable in a stall.
  assign res_data  = mul_dout;
  assign busy      = |r_vld;

endmodule

// File: tb/tb_qpsk_mul_share_arb.sv
// Testbench for qpsk_mul_share_arb: behavioural multiplier, scoreboard of
// expected {id, product} pushed on each request handshake and popped on each
// result handshake, plus table-driven and hand-written corner sequences.
module tb_qpsk_mul_share_arb;
  localparam int N_REQ   = 4;
  localparam int ID_W    = 2;
  localparam int MUL_LAT = 3;

  logic                clk;
  logic                reset_n;
  logic [N_REQ-1:0]    req_valid;
  logic [15*N_REQ-1:0] req_a;
  logic [15*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]    req_ready;
  logic                mul_ce;
  logic [14:0]         mul_din0;
  logic [14:0]         mul_din1;
  logic [29:0]         mul_dout;
  logic                res_valid;
  logic [29:0]         res_data;
  logic [ID_W-1:0]     res_id;
  logic                res_ready;
  logic                busy;

  qpsk_mul_share_arb #(.N_REQ(N_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
    .res_valid(res_valid), .res_data(res_data), .res_id(res_id), .res_ready(res_ready),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {1'b0,a} x b, 30-bit two's complement
  function automatic logic [29:0] prod(input logic [14:0] a, input logic [14:0] b);
    logic signed [29:0] ea;
    logic signed [29:0] eb;
    ea = {15'b0, a};
    eb = {{15{b[14]}}, b};
    return ea * eb;
  endfunction

  // Behavioural pipelined multiplier (not reset, like the real one).
  logic [29:0] m_pipe [MUL_LAT];
  always @(posedge clk) begin
    if (mul_ce) begin
      m_pipe[0] <= prod(mul_din0, mul_din1);
      for (int k = 1; k < MUL_LAT; k++) m_pipe[k] <= m_pipe[k-1];
    end
  end
  assign mul_dout = m_pipe[MUL_LAT-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_lat = 1'b1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          id;
    logic [29:0] data;
    int          cyc;
  } sb_t;
  sb_t sb[$];

  logic [29:0] exp_prod [N_REQ];

  // Set fresh random operands for requester i together with their product.
  task automatic set_op(input int i);
    logic [14:0] a;
    logic [14:0] b;
    a = 15'($urandom);
    b = 15'($urandom);
    req_a[i*15 +: 15] = a;
    req_b[i*15 +: 15] = b;
    exp_prod[i] = prod(a, b);
  endtask

  // Scoreboard: push on request handshake, pop/compare on result handshake.
  always @(negedge clk) begin
    sb_t e;
    if (reset_n) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_valid[i] && req_ready[i]) sb.push_back('{id: i, data: exp_prod[i], cyc: cyc});
      end
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_res_valid", 32'(res_valid), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("res_id", 32'(res_id), 32'(e.id));
          chk("res_data", 32'(res_data), 32'(e.data));
          if (chk_lat) chk("latency", 32'(cyc - e.cyc), 32'(MUL_LAT));
          $display("result id=%0d data=%0h cycle=%0d", res_id, res_data, cyc);
        end
      end
    end
  end

  typedef struct {
    int          req;
    logic [14:0] a;
    logic [14:0] b;
    logic [29:0] exp;
  } vec_t;
  vec_t vtab[4];

  typedef struct {
    logic [3:0] mask;
    logic [3:0] rdy;
  } sp_t;
  sp_t stab[13];

  task automatic do_reset();
    reset_n = 1'b0;
    req_valid = '0;
    res_ready = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    req_valid = '0;
    res_ready = 1'b1;
    repeat (MUL_LAT + 3) @(posedge clk);
    #1;
    chk(nm, 32'(sb.size()), 32'd0);
    chk_lat = 1'b1;
  endtask

  // All requesters valid continuously; optional res_ready=0 window [st, st+sl).
  task automatic rr_run(input int ncyc, input int st, input int sl);
    int nxt;
    int g;
    nxt = 0;
    chk_lat = (sl == 0);
    for (int i = 0; i < N_REQ; i++) set_op(i);
    req_valid = '1;
    for (int k = 0; k < ncyc; k++) begin
      res_ready = !(k >= st && k < st + sl);
      g = -1;
      @(negedge clk);
      if (!res_ready) begin
        chk("stall_ce", 32'(mul_ce), 32'd0);
        chk("stall_ready", 32'(req_ready), 32'd0);
        if (sb.size() > 0) begin
          chk("stall_data", 32'(res_data), 32'(sb[0].data));
          chk("stall_id", 32'(res_id), 32'(sb[0].id));
        end else begin
          chk("stall_sb_nonempty", 32'(sb.size()), 32'd1);
        end
      end else begin
        chk("rr_grant", 32'(req_ready), 32'(1) << nxt);
        g = nxt;
        nxt = (nxt + 1) % N_REQ;
      end
      @(posedge clk);
      #1;
      if (g >= 0) set_op(g);
    end
    req_valid = '0;
    res_ready = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    res_ready = 1'b1;
    for (int i = 0; i < N_REQ; i++) exp_prod[i] = '0;

    vtab[0] = '{2, 15'd100,   15'h7FFD, 30'h3FFFFED4};  // 100 * -3 = -300
    vtab[1] = '{0, 15'h7FFF,  15'h4000, 30'h20004000};  // 32767 * -16384
    vtab[2] = '{1, 15'd0,     15'h7FFF, 30'd0};         // 0 * -1
    vtab[3] = '{3, 15'h7FFF,  15'h3FFF, 30'd536821761}; // 32767 * 16383

    stab[0]  = '{4'b0010, 4'b0010};
    stab[1]  = '{4'b1000, 4'b1000};
    stab[2]  = '{4'b0000, 4'b0000};
    stab[3]  = '{4'b0010, 4'b0010};
    stab[4]  = '{4'b0000, 4'b0000};
    stab[5]  = '{4'b0000, 4'b0000};
    stab[6]  = '{4'b1000, 4'b1000};
    stab[7]  = '{4'b0010, 4'b0010};
    stab[8]  = '{4'b1010, 4'b1000};  // after 1, search from 2 -> 3
    stab[9]  = '{4'b0000, 4'b0000};  // req 1 dropped without a grant
    stab[10] = '{4'b1010, 4'b0010};  // after 3, search from 0 -> 1
    stab[11] = '{4'b0000, 4'b0000};
    stab[12] = '{4'b0000, 4'b0000};

    // Reset state, with every requester asking.
    for (int i = 0; i < N_REQ; i++) set_op(i);
    req_valid = '1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_mul_ce", 32'(mul_ce), 32'd1);
    chk("rst_din0", 32'(mul_din0), 32'd0);
    chk("rst_din1", 32'(mul_din1), 32'd0);
    req_valid = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;

    // Single requester, table of operand vectors including boundaries.
    for (int v = 0; v < 4; v++) begin
      req_a[vtab[v].req*15 +: 15] = vtab[v].a;
      req_b[vtab[v].req*15 +: 15] = vtab[v].b;
      exp_prod[vtab[v].req] = vtab[v].exp;
      req_valid = '0;
      req_valid[vtab[v].req] = 1'b1;
      @(negedge clk);
      chk("single_ready", 32'(req_ready), 32'(1) << vtab[v].req);
      chk("single_busy_pre", 32'(busy), 32'd0);
      @(posedge clk);
      #1 req_valid = '0;
      for (int j = 1; j <= MUL_LAT; j++) begin
        @(negedge clk);
        chk("single_busy", 32'(busy), 32'd1);
      end
      @(negedge clk);
      chk("single_busy_post", 32'(busy), 32'd0);
      @(posedge clk);
      #1 chk("single_drain", 32'(sb.size()), 32'd0);
    end

    // Full throughput round-robin.
    do_reset();
    rr_run(12, 0, 0);
    drain("rr_drain");

    // Backpressure for 5 cycles while results are pending.
    do_reset();
    rr_run(16, 5, 5);
    drain("bp_drain");

    // Sparse alternating requests with idle gaps.
    set_op(1);
    set_op(3);
    for (int k = 0; k < 13; k++) begin
      req_valid = stab[k].mask;
      @(negedge clk);
      chk("sparse_grant", 32'(req_ready), 32'(stab[k].rdy));
      @(posedge clk);
      #1;
      for (int i = 0; i < N_REQ; i++) if (stab[k].rdy[i]) set_op(i);
    end
    drain("sparse_drain");

    // Reset with three operations in flight.
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_op(i);
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    chk("mid_pre_valid", 32'(res_valid), 32'd1);
    chk("mid_pre_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(res_valid), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < N_REQ; i++) set_op(i);
    req_valid = '1;
    @(negedge clk);
    chk("mid_first_grant", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
    drain("mid_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
